// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV64M multiply/divide unit.
// Latency: n/a (types, constants and helper functions only).
// Backpressure: n/a.
package muldiv_pkg;

  localparam int XLEN_DEFAULT = 64;

  // funct3 encodings of the M extension
  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  function automatic logic op_is_div(input op_e op);
    return op[2];
  endfunction

  // MUL is treated as signed x signed; its low half is identical either way.
  function automatic logic op_a_signed(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic op_b_signed(input op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV64M multiply/divide: radix-2 shift-add multiply, restoring divide, on magnitudes.
// Latency: XLEN+2 cycles from the start edge to done; divide-by-zero takes 2 cycles.
// Backpressure: none; start is accepted only in IDLE and ignored while busy or in DONE.
//
// Ports:
//   clk, rst_n     - clock, asynchronous active-low reset
//   start, flush   - request pulse (latches funct3/op_a/op_b), abort of in-flight op
//   funct3         - M-extension op select
//   op_a, op_b     - rs1 / rs2 operands
//   busy, done     - high in any non-IDLE state, one-cycle result-valid pulse
//   result         - final value, held until overwritten by the next completion
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            start,
  input  logic            flush,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] op_a,
  input  logic [XLEN-1:0] op_b,
  output logic            busy,
  output logic            done,
  output logic [XLEN-1:0] result
);

  localparam logic [6:0] LAST_ITER = 7'(XLEN - 1);

  state_e state, state_nxt;

  // Latched operation context
  op_e             op_q;
  logic [XLEN-1:0] a_raw;
  logic [XLEN-1:0] b_mag;
  logic            a_neg;
  logic            b_neg;
  logic            div_zero;
  logic [6:0]      cnt;

  // acc/sreg form the 2*XLEN product {hi,lo} for multiply, and the
  // remainder/dividend-quotient pair for divide.
  logic [XLEN-1:0] acc;
  logic [XLEN-1:0] sreg;

  // Decode of the incoming request
  op_e             op_in;
  logic            a_neg_in;
  logic            b_neg_in;
  logic            div_zero_in;
  logic [XLEN-1:0] a_mag_in;
  logic [XLEN-1:0] b_mag_in;

  always_comb begin
    op_in       = op_e'(funct3);
    a_neg_in    = op_a_signed(op_in) && op_a[XLEN-1];
    b_neg_in    = op_b_signed(op_in) && op_b[XLEN-1];
    // -(-2^(XLEN-1)) wraps to 2^(XLEN-1), which is the correct unsigned magnitude
    a_mag_in    = a_neg_in ? -op_a : op_a;
    b_mag_in    = b_neg_in ? -op_b : op_b;
    div_zero_in = op_is_div(op_in) && (op_b == '0);
  end

  // One iteration of each algorithm
  logic [XLEN:0]   mul_sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN-1:0] rem_sub;
  logic            q_bit;

  always_comb begin
    mul_sum = {1'b0, acc} + (sreg[0] ? {1'b0, b_mag} : {(XLEN+1){1'b0}});
    rem_sh  = {acc, sreg[XLEN-1]};
    q_bit   = (rem_sh >= {1'b0, b_mag});
    // When q_bit is set the true difference is below b_mag, so the low XLEN bits are exact
    rem_sub = rem_sh[XLEN-1:0] - b_mag;
  end

  // Sign correction and result selection
  logic [2*XLEN-1:0] prod_fix;
  logic [XLEN-1:0]   quo_fix;
  logic [XLEN-1:0]   rem_fix;
  logic [XLEN-1:0]   fix_val;

  always_comb begin
    prod_fix = (a_neg ^ b_neg) ? -{acc, sreg} : {acc, sreg};
    quo_fix  = (a_neg ^ b_neg) ? -sreg : sreg;
    rem_fix  = a_neg ? -acc : acc;
    fix_val  = prod_fix[XLEN-1:0];
    case (op_q)
      OP_MUL:                       fix_val = prod_fix[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: fix_val = prod_fix[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              fix_val = div_zero ? '1 : quo_fix;
      OP_REM, OP_REMU:              fix_val = div_zero ? a_raw : rem_fix;
      default:                      fix_val = prod_fix[XLEN-1:0];
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // FSM: next state; flush beats everything, including a simultaneous start
  always_comb begin
    state_nxt = state;
    if (flush) begin
      state_nxt = ST_IDLE;
    end else begin
      case (state)
        ST_IDLE: if (start) state_nxt = div_zero_in ? ST_FIX : ST_CALC;
        ST_CALC: if (cnt == LAST_ITER) state_nxt = ST_FIX;
        ST_FIX:  state_nxt = ST_DONE;
        ST_DONE: state_nxt = ST_IDLE;
        default: state_nxt = ST_IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy = (state != ST_IDLE);
    done = (state == ST_DONE);
  end

  // Datapath
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= OP_MUL;
      a_raw    <= '0;
      b_mag    <= '0;
      a_neg    <= 1'b0;
      b_neg    <= 1'b0;
      div_zero <= 1'b0;
      cnt      <= 7'd0;
      acc      <= '0;
      sreg     <= '0;
      result   <= '0;
    end else if (!flush) begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            op_q     <= op_in;
            a_raw    <= op_a;
            b_mag    <= b_mag_in;
            a_neg    <= a_neg_in;
            b_neg    <= b_neg_in;
            div_zero <= div_zero_in;
            cnt      <= 7'd0;
            acc      <= '0;
            sreg     <= a_mag_in;
          end
        end
        ST_CALC: begin
          cnt <= cnt + 7'd1;
          if (op_is_div(op_q)) begin
            acc  <= q_bit ? rem_sub : rem_sh[XLEN-1:0];
            sreg <= {sreg[XLEN-2:0], q_bit};
          end else begin
            {acc, sreg} <= {mul_sum, sreg[XLEN-1:1]};
          end
        end
        ST_FIX:  result <= fix_val;
        default: ;
      endcase
    end
  end

endmodule
